// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, oversampling ratio and the
// mid-bit sample point. Reused by both the receiver and the transmitter.
package uart_pkg;

  // Oversample ticks per bit and the tick that lands in the middle of a bit.
  localparam int unsigned OVS      = 16;
  localparam int unsigned MID_TICK = 8;

  // Oversample counter values at which decisions are taken (counter is 0-based).
  localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
  localparam logic [3:0] OVS_MID  = 4'(MID_TICK - 1);

  // Index of the final data bit in an 8N1 frame.
  localparam logic [2:0] LAST_BIT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // LSB-first reception: each new bit enters at the MSB and the register
  // shifts right, so after eight bits the first one sits in bit 0.
  function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] sr,
                                                    input logic       bit_in);
    return {bit_in, sr[7:1]};
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every OVS_DIV fast_clk cycles.
// A synchronous clear restarts the period so bit timing can be aligned to
// an external event such as a start-bit falling edge.
module uart_baud_tick #(
  parameter int unsigned OVS_DIV = 130
) (
  input  logic fast_clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(OVS_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVS_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, wrap after the last count, else advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The tick is suppressed in a clear cycle so the new period starts clean.
  assign tick = (cnt_q == CNT_MAX) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. Recovers one byte per frame,
// strobes valid for a good stop bit and frame_err for a low stop bit, then
// waits in BREAK for the line to return high before accepting a new start.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVS_DIV = 130
) (
  input  logic       fast_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  logic        sync1_q;
  logic        sync2_q;
  logic        rx_s;

  uart_state_e state_q, state_d;
  logic [3:0]  ovs_q, ovs_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;

  logic        clear_s;
  logic        tick_s;

  assign rx_s = sync2_q;

  // A start candidate restarts the tick period so sampling tracks the edge.
  assign clear_s = (state_q == ST_IDLE) && !rx_s;

  uart_baud_tick #(
    .OVS_DIV(OVS_DIV)
  ) u_tick (
    .fast_clk(fast_clk),
    .rst     (rst),
    .clear   (clear_s),
    .tick    (tick_s)
  );

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM: next state, counters, shift register and output strobes.
  always_comb begin
    state_d = state_q;
    ovs_d   = ovs_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          ovs_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (tick_s) begin
          if (ovs_q == OVS_MID) begin
            if (rx_s) begin
              // Line went back high before mid start bit: a glitch.
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              ovs_d   = 4'd0;
              bit_d   = 3'd0;
            end
          end else begin
            ovs_d = ovs_q + 4'd1;
          end
        end else begin
          ovs_d = ovs_q;
        end
      end

      ST_DATA: begin
        if (tick_s) begin
          // 4-bit counter wraps naturally from 15 to 0 every bit period.
          ovs_d = ovs_q + 4'd1;
          if (ovs_q == OVS_LAST) begin
            shift_d = shift_in_lsb_first(shift_q, rx_s);
            bit_d   = bit_q + 3'd1;
            if (bit_q == LAST_BIT) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            shift_d = shift_q;
          end
        end else begin
          ovs_d = ovs_q;
        end
      end

      ST_STOP: begin
        if (tick_s) begin
          ovs_d = ovs_q + 4'd1;
          if (ovs_q == OVS_LAST) begin
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              // Low stop bit: report it, keep the previous byte, and wait
              // for the line to recover so a break is not read as frames.
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            state_d = ST_STOP;
          end
        end else begin
          ovs_d = ovs_q;
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ovs_q   <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ovs_q   <= ovs_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with OVS_DIV=4 (one bit = 64 fast_clk).
// Stimulus pushes the expected frame outcome; a monitor pops on each strobe.
module tb_uart_rx;

  localparam int OVS_DIV = 4;
  localparam int BITC    = 64;

  logic       fast_clk = 1'b0;
  logic       rst      = 1'b0;
  logic       rx       = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.OVS_DIV(OVS_DIV)) dut (
    .fast_clk (fast_clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    bit         is_err;
    logic [7:0] byte_v;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          checks = 0;
  int          passes = 0;
  logic [7:0]  last_good = 8'h00;
  int unsigned cyc = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned prev_valid_cyc = 0;
  int unsigned frame_start_cyc = 0;
  int          valid_count = 0;
  bit          prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Cycle counter for latency and spacing measurements.
  initial forever begin
    @(posedge fast_clk);
    cyc++;
  end

  // Monitor: every strobe must match the oldest expected frame outcome.
  initial forever begin
    @(negedge fast_clk);
    if (rst) begin
      if (valid || frame_err) begin
        chk("strobe_exclusive", {31'd0, valid & frame_err}, 32'd0);
        chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {24'd0, data}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
          chk("strobe_data", {24'd0, data}, {24'd0, mon_e.byte_v});
        end
        if (valid) begin
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
          valid_count++;
        end
      end
      prev_strobe = valid | frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // Reference: a good stop bit delivers the byte, a low one reports an
  // error and leaves the last good byte on the output.
  task automatic expect_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    e.is_err = !stop;
    e.byte_v = stop ? b : last_good;
    if (stop) last_good = b;
    exp_q.push_back(e);
  endtask

  // Drives one frame starting at the current negedge; leaves rx = stop.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
    expect_frame(b, stop);
    frame_start_cyc = cyc;
    rx = 1'b0;
    repeat (bc) @(negedge fast_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge fast_clk);
    end
    rx = stop;
    repeat (bc) @(negedge fast_clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge fast_clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Global time bound.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          vc0;
    int unsigned lat;
    int unsigned gap;
    logic [7:0]  b;
    logic        stop;
    int          bc;

    repeat (10) @(negedge fast_clk);
    rst = 1'b1;
    repeat (4) @(negedge fast_clk);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge fast_clk);

    // Nominal frame with latency window check.
    vc0 = valid_count;
    send_frame(8'hA5, 1'b1, BITC);
    lat = last_valid_cyc - frame_start_cyc;
    chk("a5_latency_window", {31'd0, (lat >= 32'd606 && lat <= 32'd616)}, 32'd1);
    chk("a5_valid_once", valid_count, vc0 + 1);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    wait_drain(200);

    // Short glitch: false start, no strobe.
    repeat (30) @(negedge fast_clk);
    chk("glitch_busy_before", {31'd0, busy}, 32'd0);
    rx = 1'b0;
    repeat (8) @(negedge fast_clk);
    chk("glitch_busy_during", {31'd0, busy}, 32'd1);
    repeat (8) @(negedge fast_clk);
    rx = 1'b1;
    repeat (60) @(negedge fast_clk);
    chk("glitch_busy_after", {31'd0, busy}, 32'd0);
    chk("glitch_no_strobe", exp_q.size(), 32'd0);

    // Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0, BITC);
    repeat (200) @(negedge fast_clk);
    chk("break_busy_held", {31'd0, busy}, 32'd1);
    chk("break_data_kept", {24'd0, data}, 32'hA5);
    rx = 1'b1;
    repeat (10) @(negedge fast_clk);
    chk("break_busy_release", {31'd0, busy}, 32'd0);
    wait_drain(200);
    repeat (40) @(negedge fast_clk);
    send_frame(8'h01, 1'b1, BITC);
    wait_drain(200);

    // Back-to-back frames with no idle gap.
    repeat (40) @(negedge fast_clk);
    send_frame(8'h00, 1'b1, BITC);
    send_frame(8'hFF, 1'b1, BITC);
    wait_drain(200);
    gap = last_valid_cyc - prev_valid_cyc;
    chk("b2b_spacing", {31'd0, (gap >= 32'd632 && gap <= 32'd648)}, 32'd1);

    // Reset during data bit 4: outputs clear at once, byte discarded.
    repeat (40) @(negedge fast_clk);
    b = 8'h5A;
    rx = 1'b0;
    repeat (BITC) @(negedge fast_clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge fast_clk);
    end
    rx = b[4];
    repeat (BITC / 2) @(negedge fast_clk);
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_data", {24'd0, data}, 32'h00);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge fast_clk);
    rst = 1'b1;
    repeat (BITC) @(negedge fast_clk);
    chk("midrst_no_strobe", exp_q.size(), 32'd0);
    send_frame(8'hC3, 1'b1, BITC);
    wait_drain(200);

    // +/-3% bit-period skew.
    repeat (40) @(negedge fast_clk);
    vc0 = valid_count;
    send_frame(8'h55, 1'b1, 62);
    wait_drain(200);
    chk("skew_fast_once", valid_count, vc0 + 1);
    repeat (40) @(negedge fast_clk);
    vc0 = valid_count;
    send_frame(8'h55, 1'b1, 66);
    wait_drain(200);
    chk("skew_slow_once", valid_count, vc0 + 1);

    // Randomised frames, stop bits, skew and gaps.
    for (int k = 0; k < 14; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      bc   = int'($urandom_range(62, 66));
      send_frame(b, stop, bc);
      if (!stop) begin
        repeat ($urandom_range(1, 150)) @(negedge fast_clk);
        rx = 1'b1;
        repeat ($urandom_range(8, 40)) @(negedge fast_clk);
      end else begin
        repeat ($urandom_range(0, 40)) @(negedge fast_clk);
      end
    end
    wait_drain(800);
    repeat (20) @(negedge fast_clk);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
